// File: rtl/progmem_loader_if.sv
// Bundles the fetch port and the loader port of progmem_loader.
//   master : fetch stage + host/boot loader (drives requests, receives status)
//   slave  : progmem_loader itself
// Fetch signals : fetch_en, fetch_addr -> fetch_data, fetch_valid, parity_err
// Load signals  : load_start, load_base, load_valid, load_data -> load_ready,
//                 load_ptr, load_wrap
// Status        : busy (zero-fill in progress)
interface progmem_loader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] load_ptr;
    logic              load_wrap;
    logic              busy;
    logic              parity_err;

    modport master (
        output fetch_en, fetch_addr, load_start, load_base, load_valid, load_data,
        input  fetch_data, fetch_valid, load_ready, load_ptr, load_wrap, busy, parity_err
    );

    modport slave (
        input  fetch_en, fetch_addr, load_start, load_base, load_valid, load_data,
        output fetch_data, fetch_valid, load_ready, load_ptr, load_wrap, busy, parity_err
    );
endinterface

// File: rtl/progmem_loader.sv
// Program memory for the QUAD.nibble CPU: DEPTH x DATA_W array with a registered
// fetch port and a streaming valid/ready loader with an auto-incrementing pointer.
// Zero-fills the whole array after every reset (busy high during the fill).
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : progmem_loader_if.slave (fetch port, loader port, busy, parity_err)
// Optional feature: define PROGMEM_PARITY_EN to store an even-parity bit per word
// and flag mismatches on fetch via parity_err; otherwise parity_err is tied 0.
module progmem_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input logic             clk,
    input logic             reset,
    progmem_loader_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_W;
`ifdef PROGMEM_PARITY_EN
    localparam int unsigned WordW = DATA_W + 1;
`else
    localparam int unsigned WordW = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    state_e state_q, state_d;

    logic [WordW-1:0]  mem [Depth];
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              load_wrap_q, load_wrap_d;
    logic [DATA_W-1:0] fetch_data_q;
    logic              fetch_valid_q;

    // Output-decode signals
    logic              busy;
    logic              load_ready;
    logic              fetch_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WordW-1:0]  mem_wdata;

    logic [ADDR_W-1:0] wr_ptr;
    logic [WordW-1:0]  rd_word;
    logic [WordW-1:0]  load_word;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_cnt_q == LastAddr) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // FSM: outputs and write-port decode
    always_comb begin
        busy       = 1'b0;
        load_ready = 1'b0;
        fetch_acc  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt_q;
        mem_wdata  = '0;
        unique case (state_q)
            StClear: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
            end
            StRun: begin
                load_ready = 1'b1;
                fetch_acc  = bus.fetch_en;
                mem_we     = bus.load_valid;
                mem_waddr  = wr_ptr;
                mem_wdata  = load_word;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Zero-fill counter; wraps to 0 naturally as the FSM leaves StClear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else if (state_q == StClear) begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Loader pointer. A load_start in the same cycle as an accepted word
    // redirects that word to load_base.
    // ------------------------------------------------------------------
    assign wr_ptr = bus.load_start ? bus.load_base : load_ptr_q;

`ifdef PROGMEM_PARITY_EN
    assign load_word = {^bus.load_data, bus.load_data};
`else
    assign load_word = bus.load_data;
`endif

    always_comb begin
        load_ptr_d  = load_ptr_q;
        load_wrap_d = load_wrap_q;
        if (state_q == StRun) begin
            if (bus.load_start) begin
                load_ptr_d  = bus.load_base;
                load_wrap_d = 1'b0;
            end
            if (bus.load_valid) begin
                load_ptr_d = wr_ptr + ADDR_W'(1);
                if (wr_ptr == LastAddr) begin
                    load_wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_ptr_q  <= '0;
            load_wrap_q <= 1'b0;
        end else begin
            load_ptr_q  <= load_ptr_d;
            load_wrap_q <= load_wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Gated by reset so an in-flight load word is dropped.
    // Non-blocking write gives read-before-write on a same-address fetch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[bus.fetch_addr];

    // ------------------------------------------------------------------
    // Registered fetch port; fetch_data holds when no fetch is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fetch_data_q <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef PROGMEM_PARITY_EN
    logic parity_err_q;

    // Even parity over data+parity bit must be 0 for an intact word.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= fetch_acc & (^rd_word);
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.load_ready  = load_ready;
    assign bus.load_ptr    = load_ptr_q;
    assign bus.load_wrap   = load_wrap_q;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_progmem_loader.sv
module tb_progmem_loader;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    progmem_loader_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    progmem_loader #(
        .DATA_W(16),
        .ADDR_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        total_cnt++; if (bus.fetch_data !== 16'h0) $display("FAIL rst_fetch_data: got %h want 0000", bus.fetch_data); else pass_cnt++;
        total_cnt++; if (bus.fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid: got %b want 0", bus.fetch_valid); else pass_cnt++;
        total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL rst_load_ready: got %b want 0", bus.load_ready); else pass_cnt++;
        total_cnt++; if (bus.load_ptr !== 4'h0) $display("FAIL rst_load_ptr: got %h want 0", bus.load_ptr); else pass_cnt++;
        total_cnt++; if (bus.load_wrap !== 1'b0) $display("FAIL rst_load_wrap: got %b want 0", bus.load_wrap); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.parity_err !== 1'b0) $display("FAIL rst_parity_err: got %b want 0", bus.parity_err); else pass_cnt++;
        // Release; hammer fetch and load inputs during the fill, all must be ignored.
        reset          = 1'b0;
        bus.fetch_en   = 1'b1;
        bus.load_start = 1'b1;
        bus.load_base  = 4'h5;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hFFFF;
        for (int k = 1; k <= 16; k++) begin
            bus.fetch_addr = 4'(k);
            tick();
            total_cnt++; if (bus.busy !== (k < 16)) $display("FAIL clear_busy[%0d]: got %b want %b", k, bus.busy, (k < 16)); else pass_cnt++;
            total_cnt++; if (bus.fetch_valid !== 1'b0) $display("FAIL clear_fetch_ignored[%0d]: got %b want 0", k, bus.fetch_valid); else pass_cnt++;
            total_cnt++; if (bus.load_ptr !== 4'h0) $display("FAIL clear_load_ignored[%0d]: got %h want 0", k, bus.load_ptr); else pass_cnt++;
        end
        idle_inputs();
        total_cnt++; if (bus.load_ready !== 1'b1) $display("FAIL run_load_ready: got %b want 1", bus.load_ready); else pass_cnt++;
    endtask

    task automatic test_zero_fill();
        for (int a = 0; a < 16; a++) begin
            bus.fetch_en   = 1'b1;
            bus.fetch_addr = 4'(a);
            tick();
            total_cnt++; if (bus.fetch_valid !== 1'b1) $display("FAIL zero_valid[%0d]: got %b want 1", a, bus.fetch_valid); else pass_cnt++;
            total_cnt++; if (bus.fetch_data !== 16'h0000) $display("FAIL zero_data[%0d]: got %h want 0000", a, bus.fetch_data); else pass_cnt++;
        end
        bus.fetch_en = 1'b0;
        tick();
        total_cnt++; if (bus.fetch_valid !== 1'b0) $display("FAIL zero_idle_valid: got %b want 0", bus.fetch_valid); else pass_cnt++;
        total_cnt++; if (bus.parity_err !== 1'b0) $display("FAIL zero_idle_perr: got %b want 0", bus.parity_err); else pass_cnt++;
    endtask

    task automatic test_burst();
        logic [15:0] words [3];
        logic [3:0]  ptrs  [3];
        words = '{16'hA001, 16'hA002, 16'hA003};
        ptrs  = '{4'h4, 4'h5, 4'h6};
        for (int i = 0; i < 3; i++) begin
            bus.load_start = (i == 0);
            bus.load_base  = 4'h3;
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            tick();
            total_cnt++; if (bus.load_ptr !== ptrs[i]) $display("FAIL burst_ptr[%0d]: got %h want %h", i, bus.load_ptr, ptrs[i]); else pass_cnt++;
        end
        idle_inputs();
        total_cnt++; if (bus.load_wrap !== 1'b0) $display("FAIL burst_wrap: got %b want 0", bus.load_wrap); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_en   = 1'b1;
            bus.fetch_addr = 4'(3 + i);
            tick();
            total_cnt++; if (bus.fetch_valid !== 1'b1) $display("FAIL burst_fvalid[%0d]: got %b want 1", i, bus.fetch_valid); else pass_cnt++;
            total_cnt++; if (bus.fetch_data !== words[i]) $display("FAIL burst_fdata[%0d]: got %h want %h", i, bus.fetch_data, words[i]); else pass_cnt++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_wrap();
        logic [15:0] words [3];
        logic [3:0]  ptrs  [3];
        logic [3:0]  addrs [3];
        logic        wraps [3];
        words = '{16'hB00E, 16'hB00F, 16'hB000};
        ptrs  = '{4'hF, 4'h0, 4'h1};
        addrs = '{4'hE, 4'hF, 4'h0};
        wraps = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            bus.load_start = (i == 0);
            bus.load_base  = 4'hE;
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            tick();
            total_cnt++; if (bus.load_ptr !== ptrs[i]) $display("FAIL wrap_ptr[%0d]: got %h want %h", i, bus.load_ptr, ptrs[i]); else pass_cnt++;
            total_cnt++; if (bus.load_wrap !== wraps[i]) $display("FAIL wrap_flag[%0d]: got %b want %b", i, bus.load_wrap, wraps[i]); else pass_cnt++;
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.fetch_en   = 1'b1;
            bus.fetch_addr = addrs[i];
            tick();
            total_cnt++; if (bus.fetch_data !== words[i]) $display("FAIL wrap_fdata[%0d]: got %h want %h", i, bus.fetch_data, words[i]); else pass_cnt++;
        end
        idle_inputs();
        // load_start alone clears the sticky wrap flag
        bus.load_start = 1'b1;
        bus.load_base  = 4'h2;
        tick();
        total_cnt++; if (bus.load_ptr !== 4'h2) $display("FAIL start_only_ptr: got %h want 2", bus.load_ptr); else pass_cnt++;
        total_cnt++; if (bus.load_wrap !== 1'b0) $display("FAIL start_only_wrap: got %b want 0", bus.load_wrap); else pass_cnt++;
        // load_start with base=DEPTH-1 and a word in the same cycle
        bus.load_base  = 4'hF;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hC00F;
        tick();
        total_cnt++; if (bus.load_ptr !== 4'h0) $display("FAIL start_last_ptr: got %h want 0", bus.load_ptr); else pass_cnt++;
        total_cnt++; if (bus.load_wrap !== 1'b1) $display("FAIL start_last_wrap: got %b want 1", bus.load_wrap); else pass_cnt++;
        idle_inputs();
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 4'hF;
        tick();
        total_cnt++; if (bus.fetch_data !== 16'hC00F) $display("FAIL start_last_data: got %h want c00f", bus.fetch_data); else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_read_before_write();
        bus.load_start = 1'b1;
        bus.load_base  = 4'h7;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1234;
        tick();
        bus.load_data  = 16'hBEEF;
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 4'h7;
        tick();
        total_cnt++; if (bus.fetch_data !== 16'h1234) $display("FAIL rbw_old: got %h want 1234", bus.fetch_data); else pass_cnt++;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        tick();
        total_cnt++; if (bus.fetch_data !== 16'hBEEF) $display("FAIL rbw_new: got %h want beef", bus.fetch_data); else pass_cnt++;
        bus.fetch_en = 1'b0;
        tick();
        total_cnt++; if (bus.fetch_valid !== 1'b0) $display("FAIL hold_valid: got %b want 0", bus.fetch_valid); else pass_cnt++;
        total_cnt++; if (bus.fetch_data !== 16'hBEEF) $display("FAIL hold_data: got %h want beef", bus.fetch_data); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_parity();
`ifdef PROGMEM_PARITY_EN
        dut.mem[2][0] = ~dut.mem[2][0];
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 4'h2;
        tick();
        total_cnt++; if (bus.parity_err !== 1'b1) $display("FAIL parity_bad: got %b want 1", bus.parity_err); else pass_cnt++;
`endif
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 4'h7;
        tick();
        total_cnt++; if (bus.fetch_valid !== 1'b1) $display("FAIL parity_ok_valid: got %b want 1", bus.fetch_valid); else pass_cnt++;
        total_cnt++; if (bus.parity_err !== 1'b0) $display("FAIL parity_ok: got %b want 0", bus.parity_err); else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        // Reset in the middle of CLEAR
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mid_clear_busy: got %b want 1", bus.busy); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total_cnt++; if (bus.busy !== (k < 16)) $display("FAIL mid_clear_restart[%0d]: got %b want %b", k, bus.busy, (k < 16)); else pass_cnt++;
        end
        // Reset in the middle of a burst, with a word in flight
        bus.load_start = 1'b1;
        bus.load_base  = 4'h3;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1111;
        tick();
        bus.load_start = 1'b0;
        bus.load_data  = 16'h2222;
        tick();
        total_cnt++; if (bus.load_ptr !== 4'h5) $display("FAIL mid_burst_ptr: got %h want 5", bus.load_ptr); else pass_cnt++;
        bus.load_data = 16'h3333;
        reset         = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        total_cnt++; if (bus.load_ptr !== 4'h0) $display("FAIL mid_burst_rst_ptr: got %h want 0", bus.load_ptr); else pass_cnt++;
        total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL mid_burst_rst_ready: got %b want 0", bus.load_ready); else pass_cnt++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total_cnt++; if (bus.busy !== (k < 16)) $display("FAIL mid_burst_restart[%0d]: got %b want %b", k, bus.busy, (k < 16)); else pass_cnt++;
        end
        begin
            logic [3:0] addrs [5];
            addrs = '{4'h3, 4'h4, 4'h5, 4'h7, 4'hE};
            for (int i = 0; i < 5; i++) begin
                bus.fetch_en   = 1'b1;
                bus.fetch_addr = addrs[i];
                tick();
                total_cnt++; if (bus.fetch_data !== 16'h0000) $display("FAIL mid_reset_cleared[%h]: got %h want 0000", addrs[i], bus.fetch_data); else pass_cnt++;
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_fill();
        test_burst();
        test_wrap();
        test_read_before_write();
        test_parity();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/progmem_loader.md
# progmem_loader

Parametrised program memory for the QUAD.nibble CPU. Widens the fixed 16×16 progmem into a DEPTH×DATA_W array with a registered instruction-fetch port and a streaming loader port (valid/ready, auto-incrementing pointer). On reset it zero-fills the whole array. It sits between the fetch stage (read port) and the host/boot loader (write port).

## Interface
- DATA_W, 16, word width in bits (≥4)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_en  in  1  fetch request this cycle
- fetch_addr  in  ADDR_W  fetch address
- fetch_data  out  DATA_W  registered read data
- fetch_valid  out  1  fetch_data holds the result of the previous cycle's accepted fetch
- load_start  in  1  set load pointer to load_base
- load_base  in  ADDR_W  start address for a load burst
- load_valid  in  1  load_data present
- load_data  in  DATA_W  word to write
- load_ready  out  1  block can accept a load word
- load_ptr  out  ADDR_W  address the next accepted word is written to
- load_wrap  out  1  sticky: pointer wrapped DEPTH-1→0 since last load_start
- busy  out  1  zero-fill in progress
- parity_err  out  1  only with PROGMEM_PARITY_EN (see Configuration)

## Operation
- States: CLEAR, RUN. reset → CLEAR, clear counter = 0.
- CLEAR: each cycle writes 0 to word[counter], counter++; after writing word DEPTH-1 → RUN. busy=1, load_ready=0, fetches ignored (fetch_valid stays 0).
- RUN: busy=0, load_ready=1.
- Fetch accepted when state=RUN and fetch_en=1; next cycle fetch_data=word[fetch_addr], fetch_valid=1. No accepted fetch → fetch_valid=0, fetch_data holds last value.
- Load word accepted when load_valid && load_ready: word[load_ptr] ← load_data, load_ptr ← load_ptr+1 (mod DEPTH). Increment from DEPTH-1 sets load_wrap.
- load_start (RUN only): load_ptr ← load_base, load_wrap ← 0. Same cycle as an accepted word: word written at load_base, load_ptr ← load_base+1; if load_base=DEPTH-1, load_ptr ← 0 and load_wrap ← 1.
- load_start in CLEAR: ignored.
- Fetch and write to same address in same cycle: read-before-write; fetch_data returns old word, new word visible to fetches from next cycle.
- reset asserted in any state (including mid-CLEAR or mid-burst): restart CLEAR from word 0; in-flight load word discarded.

## Timing
- Reset values (cycle after reset sampled high): fetch_data=0, fetch_valid=0, load_ready=0, load_ptr=0, load_wrap=0, busy=1, parity_err=0.
- busy high for exactly DEPTH cycles after reset deasserts; load_ready rises the same edge busy falls.
- Fetch latency 1 cycle, one fetch per cycle, full throughput.
- Load throughput one word per cycle; load_ready never deasserts in RUN.
- load_ptr/load_wrap update on the edge that accepts the word or load_start.

## Configuration
- PROGMEM_PARITY_EN defined: each word stores an extra even-parity bit computed on write (zero-fill stores parity 0). On each accepted fetch, parity recomputed; parity_err=1 in the same cycle as fetch_valid if mismatch, else 0. parity_err is 0 whenever fetch_valid=0.
- Undefined: no parity storage; parity_err port still present, tied 0.

## Test plan
- Reset, hold 1 cycle, release → busy=1 for 16 cycles, then load_ready=1; fetch addr 0x0..0xF each returns 0x0000 with fetch_valid one cycle later.
- load_start base=0x3, stream 0xA001,0xA002,0xA003 → load_ptr=0x6; fetch 0x3,0x4,0x5 returns 0xA001,0xA002,0xA003 back-to-back.
- load_start base=0xE, stream 3 words → words at 0xE,0xF,0x0; load_wrap=1 after second word, load_ptr=0x1.
- Write 0xBEEF to 0x7 while fetching 0x7 (previously 0x1234) same cycle → fetch_data=0x1234; next-cycle fetch of 0x7 → 0xBEEF.
- Assert reset after 5 CLEAR cycles, and again mid-burst → busy restarts for full 16 cycles; previously loaded words read 0x0000; load_ptr=0.
- With PROGMEM_PARITY_EN: force-flip one stored bit at 0x2 → fetch 0x2 gives parity_err=1 with fetch_valid; fetch of an intact word gives parity_err=0.
